link_tx_ctrl: RTL
=================

LINK_TX_CTRL -- requirements
Module: link_tx_ctrl

Interface
REQ-001 Parameter INIT_COMMAS, default 4: number of comma symbols sent in INIT before data may be accepted; legal range 1..15.
REQ-002 Parameter SKIP_INTERVAL, default 16: cycles between SKP symbols; legal range 2..255; used only with SKIP_INSERT_EN.
REQ-003 clk_4f  input  1: the single clock, byte rate of the parallel-serial datapath; all state changes on its rising edge.
REQ-004 reset  input  1: synchronous, active-low reset; sampled on the rising edge of clk_4f.
REQ-005 link_en  input  1: link enable; low forces re-training.
REQ-006 valid_in  input  1: requester presents a byte on data_in.
REQ-007 data_in  input  8: payload byte.
REQ-008 ready  output  1: combinational; a byte transfers when valid_in and ready are both high at a rising edge.
REQ-009 data_out  output  8: registered byte to the serializer.
REQ-010 active  output  1: registered; high when data_out carries payload.
REQ-011 inserter  output  1: registered; high when data_out carries a controller-inserted symbol (0xBC or 0x1C).

Function
REQ-012 States: INIT, IDLE, ACTIVE; 4-bit comma counter; 8-bit skip counter.
REQ-013 INIT: ready=0; each cycle with link_en=1, next data_out=0xBC, inserter=1, active=0, and the counter increments.
REQ-014 INIT with link_en=0: next data_out=0x00, inserter=0, active=0; the counter holds.
REQ-015 INIT -> IDLE on the edge where the counter equals INIT_COMMAS-1 with link_en=1, giving exactly INIT_COMMAS commas; the counter clears.
REQ-016 IDLE/ACTIVE: ready=1 unless a SKP is due (REQ-024).
REQ-017 Transfer: next data_out=data_in, active=1, inserter=0; state -> ACTIVE; one-cycle latency from transfer edge to data_out.
REQ-018 IDLE/ACTIVE with no transfer: next data_out=0xBC, inserter=1, active=0; state -> IDLE.
REQ-019 link_en=0 in IDLE/ACTIVE: state -> INIT, comma counter clears, ready=0 combinationally in that cycle, no transfer occurs, and next data_out=0x00 with active=0 and inserter=0.
REQ-020 active and inserter are never high together; data_out is never payload while active=0.
REQ-021 valid_in and data_in are ignored whenever ready=0; the requester holds its byte until accepted.

Reset
REQ-022 reset=0 at an edge: state=INIT, both counters=0, data_out=0x00, active=0, inserter=0; ready=0 from that edge.
REQ-023 reset overrides link_en and a concurrent transfer; a reset mid-payload drops the byte and the next byte restarts with INIT_COMMAS commas.

Configuration
REQ-024 With SKIP_INSERT_EN defined: the skip counter increments each IDLE/ACTIVE cycle; when it equals SKIP_INTERVAL-1, ready=0 for one cycle, next data_out=0x1C, inserter=1, active=0; the counter then wraps to 0, and the state is unchanged.
REQ-025 With SKIP_INSERT_EN defined: the skip counter clears on reset and on entry to INIT; SKP takes priority over a pending valid_in.
REQ-026 Without SKIP_INSERT_EN: no skip counter is built, 0x1C is never emitted, and ready depends only on state.

Verification
REQ-027 reset=0 for 2 edges, then reset=1 with link_en=1 and valid_in=1, data_in=0xA5 -> four cycles of data_out=0xBC with inserter=1 and ready=0; then ready=1; the next data_out=0xA5 with active=1.
REQ-028 In ACTIVE, stream 0x01,0x02,0x03 back-to-back, then drop valid_in -> data_out follows 0x01,0x02,0x03 one cycle late, then 0xBC with inserter=1, and the state returns to IDLE.
REQ-029 link_en=1 held for 2 INIT cycles, then low for 3 cycles, then high again -> two commas, then three cycles of 0x00, then two more commas, with ready rising after the fourth comma.
REQ-030 Drive link_en=0 in the same cycle as valid_in=1, data_in=0x5A -> no transfer, data_out=0x00 next, and INIT restarts with 4 commas.
REQ-031 SKIP_INSERT_EN, SKIP_INTERVAL=16, continuous valid_in -> data_out=0x1C with ready=0 on every 16th IDLE/ACTIVE cycle, with no payload byte lost or duplicated.
REQ-032 Assert reset=0 mid-stream with data_in=0x77 accepted -> data_out=0x00 and active=0 on the next edge, and 0x77 never appears.

Source files
------------

// File: rtl/link_tx_ctrl_if.sv
// Requester/serializer bus for link_tx_ctrl.
// master: the requester side; slave: the controller.
interface link_tx_ctrl_if;
  logic       link_en;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready;
  logic [7:0] data_out;
  logic       active;
  logic       inserter;

  modport master (
    output link_en, valid_in, data_in,
    input  ready, data_out, active, inserter
  );

  modport slave (
    input  link_en, valid_in, data_in,
    output ready, data_out, active, inserter
  );
endinterface

// File: rtl/link_tx_ctrl.sv
// Link transmit controller: trains the link with commas, then passes payload
// bytes to the serializer, filling idle cycles with commas.
// Optional SKP insertion is built when SKIP_INSERT_EN is defined.
module link_tx_ctrl #(
  parameter int INIT_COMMAS   = 4,   // 1..15
  parameter int SKIP_INTERVAL = 16   // 2..255, used with SKIP_INSERT_EN
) (
  input logic           clk_4f,
  input logic           reset,
  link_tx_ctrl_if.slave bus
);

  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] SKP   = 8'h1C;

  // Reject out-of-range configurations at elaboration.
  if (INIT_COMMAS < 1 || INIT_COMMAS > 15 ||
      SKIP_INTERVAL < 2 || SKIP_INTERVAL > 255) begin : g_bad_params
    $error("link_tx_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {INIT, IDLE, ACTIVE} state_t;

  state_t     state, state_nxt;
  logic [3:0] comma_cnt, comma_cnt_nxt;
  logic [7:0] dout, dout_nxt;
  logic       act, act_nxt;
  logic       ins, ins_nxt;
  logic       skp_due;
  logic       xfer;

`ifdef SKIP_INSERT_EN
  logic [7:0] skip_cnt, skip_cnt_nxt;

  // SKP falls due once the interval has elapsed in IDLE/ACTIVE.
  assign skp_due = (state != INIT) && (skip_cnt == 8'(SKIP_INTERVAL - 1));

  // Skip counter: runs in IDLE/ACTIVE, wraps on SKP, clears on entering INIT.
  always_comb begin
    skip_cnt_nxt = skip_cnt;
    if (state == INIT || !bus.link_en) skip_cnt_nxt = '0;
    else if (skp_due)                  skip_cnt_nxt = '0;
    else                               skip_cnt_nxt = skip_cnt + 8'd1;
  end

  // Skip counter register.
  always_ff @(posedge clk_4f) begin
    if (!reset) skip_cnt <= '0;
    else        skip_cnt <= skip_cnt_nxt;
  end
`else
  assign skp_due = 1'b0;
`endif

  // Reset is folded in so a requester never sees a handshake that reset discards.
  assign bus.ready = reset && bus.link_en && (state != INIT) && !skp_due;
  assign xfer      = bus.ready && bus.valid_in;

  // Next state and next output symbol.
  always_comb begin
    state_nxt     = state;
    comma_cnt_nxt = comma_cnt;
    dout_nxt      = 8'h00;
    act_nxt       = 1'b0;
    ins_nxt       = 1'b0;
    case (state)
      INIT: begin
        if (bus.link_en) begin
          dout_nxt = COMMA;
          ins_nxt  = 1'b1;
          if (comma_cnt == 4'(INIT_COMMAS - 1)) begin
            state_nxt     = IDLE;
            comma_cnt_nxt = '0;
          end else begin
            comma_cnt_nxt = comma_cnt + 4'd1;
          end
        end
      end
      default: begin
        if (!bus.link_en) begin
          state_nxt     = INIT;
          comma_cnt_nxt = '0;
        end else if (skp_due) begin
          dout_nxt = SKP;
          ins_nxt  = 1'b1;
        end else if (xfer) begin
          state_nxt = ACTIVE;
          dout_nxt  = bus.data_in;
          act_nxt   = 1'b1;
        end else begin
          state_nxt = IDLE;
          dout_nxt  = COMMA;
          ins_nxt   = 1'b1;
        end
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state     <= INIT;
      comma_cnt <= '0;
      dout      <= 8'h00;
      act       <= 1'b0;
      ins       <= 1'b0;
    end else begin
      state     <= state_nxt;
      comma_cnt <= comma_cnt_nxt;
      dout      <= dout_nxt;
      act       <= act_nxt;
      ins       <= ins_nxt;
    end
  end

  assign bus.data_out = dout;
  assign bus.active   = act;
  assign bus.inserter = ins;

endmodule
